// File: rtl/pe_pkg.sv
// Shared definitions for the PE control sequencer: FSM states, kernel modes,
// default address widths and the mode-to-kernel-size mapping.
package pe_pkg;

    localparam int PMEM_ADDR_WIDTH_DEF = 8;
    localparam int WMEM_ADDR_WIDTH_DEF = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WLOAD    = 3'd1,
        ST_WLATCH   = 3'd2,
        ST_PREFETCH = 3'd3,
        ST_RUN      = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_K3 = 2'b00,
        MODE_K4 = 2'b01,
        MODE_K5 = 2'b10,
        MODE_K6 = 2'b11
    } mode_e;

    // Kernel size K (number of weight phases) for a given mode
    function automatic logic [2:0] mode_to_k(input logic [1:0] mode);
        logic [2:0] k;
        case (mode_e'(mode))
            MODE_K3: k = 3'd3;
            MODE_K4: k = 3'd4;
            MODE_K5: k = 3'd5;
            MODE_K6: k = 3'd6;
            default: k = 3'd3;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/pe_step_cnt.sv
// Per-channel beat counter plus the modulo-K weight phase counter.
// Both advance only on an accepted beat and clear together on the last beat
// of a channel or on a job start.
module pe_step_cnt #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_acc,
    input  logic [AW-1:0] i_step_num,
    input  logic [2:0]    i_k,
    output logic [AW-1:0] o_step_cnt,
    output logic [2:0]    o_shift_cnt,
    output logic          o_last
);

    logic [AW-1:0] r_step_cnt;
    logic [2:0]    r_shift_cnt;
    logic          w_last;

    assign w_last      = (r_step_cnt == (i_step_num - AW'(1)));
    assign o_last      = w_last;
    assign o_step_cnt  = r_step_cnt;
    assign o_shift_cnt = r_shift_cnt;

    // Advance step/phase on accept, wrap phase at K-1, clear at channel end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_cnt  <= '0;
            r_shift_cnt <= 3'd0;
        end else if (i_clr) begin
            r_step_cnt  <= '0;
            r_shift_cnt <= 3'd0;
        end else if (i_acc) begin
            if (w_last) begin
                r_step_cnt  <= '0;
                r_shift_cnt <= 3'd0;
            end else begin
                r_step_cnt  <= r_step_cnt + AW'(1);
                r_shift_cnt <= (r_shift_cnt == (i_k - 3'd1)) ? 3'd0 : (r_shift_cnt + 3'd1);
            end
        end else begin
            r_step_cnt  <= r_step_cnt;
            r_shift_cnt <= r_shift_cnt;
        end
    end

endmodule

// File: rtl/pe_ctrl.sv
// Control sequencer for one PE: per channel it loads the weight row set,
// primes the pmem read pipeline, then streams image beats while the psums
// accumulate in pmem (bias on channel 0, previous psum afterwards).
module pe_ctrl
    import pe_pkg::*;
#(
    parameter int PMEM_ADDR_WIDTH = PMEM_ADDR_WIDTH_DEF,
    parameter int WMEM_ADDR_WIDTH = WMEM_ADDR_WIDTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [1:0]                 i_mode,
    input  logic [3:0]                 i_psum_shift,
    input  logic [PMEM_ADDR_WIDTH-1:0] i_step_num,
    input  logic [WMEM_ADDR_WIDTH-1:0] i_ch_num,
    input  logic [WMEM_ADDR_WIDTH-1:0] i_wmem_base,
    input  logic                       i_img_valid,
    output logic                       o_img_ready,
    output logic [1:0]                 o_mode,
    output logic [3:0]                 o_psum_shift,
    output logic [2:0]                 o_wgt_shift,
    output logic                       o_bias_sel,
    output logic                       o_update_bias,
    output logic [WMEM_ADDR_WIDTH-1:0] o_wmem_rd_addr,
    output logic                       o_update_wgt,
    output logic                       o_pmem_rd_en0,
    output logic                       o_pmem_rd_en1,
    output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_rd_addr0,
    output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_rd_addr1,
    output logic                       o_pmem_wr_en0,
    output logic                       o_pmem_wr_en1,
    output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_wr_addr0,
    output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_wr_addr1,
    output logic                       o_busy,
    output logic                       o_done
);

    state_e                     r_state;
    logic [1:0]                 r_mode;
    logic [3:0]                 r_psum_shift;
    logic [PMEM_ADDR_WIDTH-1:0] r_step_num;
    logic [WMEM_ADDR_WIDTH-1:0] r_ch_num;
    logic [WMEM_ADDR_WIDTH-1:0] r_wmem_base;
    logic [WMEM_ADDR_WIDTH-1:0] r_ch_cnt;

    logic                       w_start_ok;
    logic                       w_acc;
    logic                       w_last;
    logic [PMEM_ADDR_WIDTH-1:0] w_step_cnt;
    logic [2:0]                 w_shift_cnt;

    // A start is honoured only while not busy (IDLE or the DONE cycle)
    assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_acc      = (r_state == ST_RUN) & i_img_valid;

    pe_step_cnt #(
        .AW (PMEM_ADDR_WIDTH)
    ) u_step_cnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_start_ok),
        .i_acc       (w_acc),
        .i_step_num  (r_step_num),
        .i_k         (mode_to_k(r_mode)),
        .o_step_cnt  (w_step_cnt),
        .o_shift_cnt (w_shift_cnt),
        .o_last      (w_last)
    );

    // Job FSM: descriptor latch, channel sequencing and completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= 2'd0;
            r_psum_shift <= 4'd0;
            r_step_num   <= '0;
            r_ch_num     <= '0;
            r_wmem_base  <= '0;
            r_ch_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_mode       <= i_mode;
                        r_psum_shift <= i_psum_shift;
                        r_step_num   <= i_step_num;
                        r_ch_num     <= i_ch_num;
                        r_wmem_base  <= i_wmem_base;
                        r_ch_cnt     <= '0;
                        r_state      <= ((i_step_num == '0) || (i_ch_num == '0)) ? ST_DONE : ST_WLOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WLOAD:    r_state <= ST_WLATCH;
                ST_WLATCH:   r_state <= ST_PREFETCH;
                ST_PREFETCH: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_acc && w_last) begin
                        if (r_ch_cnt == (r_ch_num - WMEM_ADDR_WIDTH'(1))) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + WMEM_ADDR_WIDTH'(1);
                            r_state  <= ST_WLOAD;
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mode       = r_mode;
    assign o_psum_shift = r_psum_shift;
    assign o_wgt_shift  = w_shift_cnt;
    assign o_bias_sel   = (r_ch_cnt != '0);

    // Strobe, enable and address decode; pmem enables in RUN follow the accept
    always_comb begin
        o_img_ready     = 1'b0;
        o_update_bias   = 1'b0;
        o_update_wgt    = 1'b0;
        o_wmem_rd_addr  = '0;
        o_pmem_rd_en0   = 1'b0;
        o_pmem_rd_en1   = 1'b0;
        o_pmem_rd_addr0 = '0;
        o_pmem_rd_addr1 = '0;
        o_pmem_wr_en0   = 1'b0;
        o_pmem_wr_en1   = 1'b0;
        o_pmem_wr_addr0 = '0;
        o_pmem_wr_addr1 = '0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        case (r_state)
            ST_WLOAD: begin
                o_busy         = 1'b1;
                o_wmem_rd_addr = r_wmem_base + r_ch_cnt;
            end
            ST_WLATCH: begin
                o_busy        = 1'b1;
                o_update_wgt  = 1'b1;
                o_update_bias = (r_ch_cnt == '0);
            end
            ST_PREFETCH: begin
                o_busy        = 1'b1;
                o_pmem_rd_en0 = 1'b1;
                o_pmem_rd_en1 = 1'b1;
            end
            ST_RUN: begin
                o_busy          = 1'b1;
                o_img_ready     = 1'b1;
                o_pmem_wr_en0   = w_acc;
                o_pmem_wr_en1   = w_acc;
                o_pmem_wr_addr0 = w_step_cnt;
                o_pmem_wr_addr1 = w_step_cnt;
                o_pmem_rd_en0   = w_acc & ~w_last;
                o_pmem_rd_en1   = w_acc & ~w_last;
                o_pmem_rd_addr0 = w_step_cnt + PMEM_ADDR_WIDTH'(1);
                o_pmem_rd_addr1 = w_step_cnt + PMEM_ADDR_WIDTH'(1);
            end
            ST_DONE: o_done = 1'b1;
            default: o_done = 1'b0;
        endcase
    end

endmodule
